// File: rtl/uart_gen2_pkg.sv
// uart_gen2_pkg: shared FSM encoding, parity modes and bit-timing constants
// for the uart_gen2 core.
package uart_gen2_pkg;

  // Shared by the TX and RX FSMs; ST_BREAK is only reachable on the RX side
  // when break detection is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int TICKS_PER_BIT = 8;
  localparam int SAMPLE_TICK   = 4;

  // Parity bit to transmit for zero-extended data under the given mode.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_gen2_fifo.sv
// uart_gen2_fifo: synchronous first-word-fall-through FIFO. The head word is
// visible on o_dout whenever o_empty is low; o_dout reads 0 when empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module uart_gen2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Storage write; contents need no reset because o_dout is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Read/write pointers with one wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_gen2.sv
// uart_gen2: parametrised UART core with an FWFT RX FIFO and sticky
// overrun/framing/parity flags. Core-side polarity: mark = 0, space = 1.
// Optional feature macro: UART_BREAK_DETECT_EN enables line-break detection
// on rxbreak; without it rxbreak is tied low and a break reads as a zero
// byte with a framing error.
//
// state     | meaning
// ST_IDLE   | line idle (mark), waiting for load (TX) or a space (RX)
// ST_START  | start bit: TX drives space, RX confirms it at the sample tick
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only when PARITY != 0)
// ST_STOP   | stop bit(s): TX drives mark, RX samples the first one
// ST_BREAK  | RX only: line held at space, waiting for one bit of mark
module uart_gen2
  import uart_gen2_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int CLKDIV      = 13,
  parameter int PARITY      = 0,
  parameter int STOPBITS    = 1,
  parameter int RXFIFODEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cte1,
  input  logic                load,
  input  logic [DATABITS-1:0] d,
  output logic                txbusy,
  output logic                txpin,
  input  logic                rxpin,
  output logic                bitx8ce,
  input  logic                rd,
  output logic [DATABITS-1:0] q,
  output logic                rxvalid,
  output logic                rxoverrun,
  output logic                rxframeerr,
  output logic                rxparityerr,
  input  logic                clrerr,
  output logic                rxbreak
);

  localparam int PW = $clog2(CLKDIV);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick  = cte1 && (r_presc == PW'(CLKDIV - 1));
  assign bitx8ce = w_tick;

  // 8x bit-rate prescaler, advancing only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_presc <= '0;
    else if (cte1) r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  uart_state_e         r_tx_state, w_tx_state_nxt;
  logic [2:0]          r_tx_tick, w_tx_tick_nxt;
  logic [3:0]          r_tx_cnt, w_tx_cnt_nxt;
  logic [DATABITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic                r_tx_par, w_tx_par_nxt, r_txpin, w_txpin_nxt, w_tx_bitend;

  // The tick counter counts down through each bit; wrapping 0 -> 7 reloads it.
  assign w_tx_bitend = w_tick && (r_tx_tick == 3'd0);
  assign txbusy      = (r_tx_state != ST_IDLE);
  assign txpin       = r_txpin;

  // TX next state; txpin is derived from the next state so the pad is registered.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tick_nxt  = w_tick ? r_tx_tick - 3'd1 : r_tx_tick;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    case (r_tx_state)
      ST_IDLE: if (load) begin
        w_tx_state_nxt = ST_START;
        w_tx_tick_nxt  = 3'(TICKS_PER_BIT - 1);
        w_tx_shift_nxt = d;
        w_tx_par_nxt   = parity_bit(9'(d), PARITY);
      end
      ST_START: if (w_tx_bitend) begin
        w_tx_state_nxt = ST_DATA;
        w_tx_cnt_nxt   = 4'(DATABITS - 1);
      end
      ST_DATA: if (w_tx_bitend) begin
        w_tx_shift_nxt = r_tx_shift >> 1;
        if (r_tx_cnt == 4'd0) begin
          w_tx_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          w_tx_cnt_nxt   = 4'(STOPBITS - 1);
        end else begin
          w_tx_cnt_nxt = r_tx_cnt - 4'd1;
        end
      end
      ST_PARITY: if (w_tx_bitend) w_tx_state_nxt = ST_STOP;
      ST_STOP: if (w_tx_bitend) begin
        if (r_tx_cnt == 4'd0) w_tx_state_nxt = ST_IDLE;
        else                  w_tx_cnt_nxt   = r_tx_cnt - 4'd1;
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
    case (w_tx_state_nxt)
      ST_START:  w_txpin_nxt = 1'b1;
      ST_DATA:   w_txpin_nxt = ~w_tx_shift_nxt[0];
      ST_PARITY: w_txpin_nxt = ~w_tx_par_nxt;
      default:   w_txpin_nxt = 1'b0;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_tick  <= '0;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txpin    <= 1'b0;
    end else if (cte1) begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_tick  <= w_tx_tick_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_txpin    <= w_txpin_nxt;
    end
  end

  uart_state_e         r_rx_state, w_rx_state_nxt;
  logic [1:0]          r_rx_sync;
  logic [2:0]          r_rx_tick, w_rx_tick_nxt;
  logic [3:0]          r_rx_cnt, w_rx_cnt_nxt;
  logic [DATABITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic                r_rx_par, w_rx_par_nxt;
  logic                w_rx_space, w_rx_sample, w_rx_push, w_set_fe, w_set_pe;
`ifdef UART_BREAK_DETECT_EN
  logic                r_rx_brk, w_rx_brk_nxt;
  logic [3:0]          r_rx_mark, w_rx_mark_nxt;
`endif

  assign w_rx_space  = r_rx_sync[1];
  assign w_rx_sample = w_tick && (r_rx_tick == 3'(SAMPLE_TICK - 1));

  // RX next state; the tick counter restarts at the detected start edge.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tick_nxt  = w_tick ? r_rx_tick + 3'd1 : r_rx_tick;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_par_nxt   = r_rx_par;
    w_rx_push      = 1'b0;
    w_set_fe       = 1'b0;
    w_set_pe       = 1'b0;
`ifdef UART_BREAK_DETECT_EN
    w_rx_brk_nxt   = r_rx_brk;
    w_rx_mark_nxt  = r_rx_mark;
`endif
    case (r_rx_state)
      ST_IDLE: if (w_rx_space) begin
        w_rx_state_nxt = ST_START;
        w_rx_tick_nxt  = '0;
      end
      ST_START: if (w_rx_sample) begin
        w_rx_state_nxt = w_rx_space ? ST_DATA : ST_IDLE;
        w_rx_cnt_nxt   = '0;
      end
      ST_DATA: if (w_rx_sample) begin
        w_rx_shift_nxt = {~w_rx_space, r_rx_shift[DATABITS-1:1]};
        if (r_rx_cnt == 4'(DATABITS - 1))
          w_rx_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        else
          w_rx_cnt_nxt = r_rx_cnt + 4'd1;
      end
      ST_PARITY: if (w_rx_sample) begin
        w_rx_par_nxt   = ~w_rx_space;
        w_rx_state_nxt = ST_STOP;
      end
      ST_STOP: if (w_rx_sample) begin
        w_rx_state_nxt = ST_IDLE;
`ifdef UART_BREAK_DETECT_EN
        if (w_rx_space && (r_rx_shift == '0) && !r_rx_par) begin
          w_rx_state_nxt = ST_BREAK;
          w_rx_mark_nxt  = '0;
        end else
`endif
        begin
          w_rx_push = 1'b1;
          w_set_fe  = w_rx_space;
          w_set_pe  = (PARITY != PAR_NONE) && (r_rx_par != parity_bit(9'(r_rx_shift), PARITY));
        end
      end
`ifdef UART_BREAK_DETECT_EN
      ST_BREAK: begin
        if (w_rx_space)  w_rx_mark_nxt = '0;
        else if (w_tick) w_rx_mark_nxt = r_rx_mark + 4'd1;
        // Raise the flag at the bit boundary that completes the all-space frame.
        if (w_tick && w_rx_space && (r_rx_tick == 3'(TICKS_PER_BIT - 1))) w_rx_brk_nxt = 1'b1;
        if (w_tick && !w_rx_space && (r_rx_mark == 4'(TICKS_PER_BIT - 1))) begin
          w_rx_brk_nxt   = 1'b0;
          w_rx_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  // RX synchroniser and state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync  <= '0;
      r_rx_state <= ST_IDLE;
      r_rx_tick  <= '0;
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      r_rx_brk   <= 1'b0;
      r_rx_mark  <= '0;
`endif
    end else if (cte1) begin
      r_rx_sync  <= {r_rx_sync[0], rxpin};
      r_rx_state <= w_rx_state_nxt;
      r_rx_tick  <= w_rx_tick_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_par   <= w_rx_par_nxt;
`ifdef UART_BREAK_DETECT_EN
      r_rx_brk   <= w_rx_brk_nxt;
      r_rx_mark  <= w_rx_mark_nxt;
`endif
    end
  end

`ifdef UART_BREAK_DETECT_EN
  assign rxbreak = r_rx_brk;
`else
  assign rxbreak = 1'b0;
`endif

  logic w_pop, w_full, w_empty, w_set_ovr;
  logic r_ovr, r_fe, r_pe;

  assign w_pop       = rd && cte1;
  assign w_set_ovr   = w_rx_push && w_full && !w_pop;
  assign rxvalid     = !w_empty;
  assign rxoverrun   = r_ovr;
  assign rxframeerr  = r_fe;
  assign rxparityerr = r_pe;

  uart_gen2_fifo #(
    .WIDTH (DATABITS),
    .DEPTH (RXFIFODEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_din   (w_rx_shift_nxt),
    .i_pop   (w_pop),
    .o_dout  (q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky error flags; a set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
      r_fe  <= 1'b0;
      r_pe  <= 1'b0;
    end else if (cte1) begin
      r_ovr <= (r_ovr && !clrerr) || w_set_ovr;
      r_fe  <= (r_fe  && !clrerr) || w_set_fe;
      r_pe  <= (r_pe  && !clrerr) || w_set_pe;
    end
  end

endmodule

// File: tb/tb_uart_gen2.sv
// tb_uart_gen2: directed checks for uart_gen2 using an 8N1 instance (a_*) and
// a 7E1 instance (b_*), both at CLKDIV=4 so one bit time is 32 clocks.
`timescale 1ns/1ps
module tb_uart_gen2;

  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cte1;

  logic       a_load, a_txbusy, a_txpin, a_rxpin, a_bitx8ce, a_rd, a_rxvalid;
  logic       a_ovr, a_fe, a_pe, a_clrerr, a_brk, a_loop, a_drv;
  logic [7:0] a_d, a_q;
  logic       b_load, b_txbusy, b_txpin, b_rxpin, b_bitx8ce, b_rd, b_rxvalid;
  logic       b_ovr, b_fe, b_pe, b_clrerr, b_brk, b_loop, b_drv;
  logic [6:0] b_d, b_q;

  assign a_rxpin = a_loop ? a_txpin : a_drv;
  assign b_rxpin = b_loop ? b_txpin : b_drv;

  uart_gen2 #(.DATABITS(8), .CLKDIV(4), .PARITY(0), .STOPBITS(1), .RXFIFODEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cte1(cte1), .load(a_load), .d(a_d), .txbusy(a_txbusy),
    .txpin(a_txpin), .rxpin(a_rxpin), .bitx8ce(a_bitx8ce), .rd(a_rd), .q(a_q),
    .rxvalid(a_rxvalid), .rxoverrun(a_ovr), .rxframeerr(a_fe), .rxparityerr(a_pe),
    .clrerr(a_clrerr), .rxbreak(a_brk));

  uart_gen2 #(.DATABITS(7), .CLKDIV(4), .PARITY(2), .STOPBITS(1), .RXFIFODEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cte1(cte1), .load(b_load), .d(b_d), .txbusy(b_txbusy),
    .txpin(b_txpin), .rxpin(b_rxpin), .bitx8ce(b_bitx8ce), .rd(b_rd), .q(b_q),
    .rxvalid(b_rxvalid), .rxoverrun(b_ovr), .rxframeerr(b_fe), .rxparityerr(b_pe),
    .clrerr(b_clrerr), .rxbreak(b_brk));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load_a(input logic [7:0] v);
    a_d = v; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
  endtask

  task automatic pulse_load_b(input logic [6:0] v);
    b_d = v; b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (a_txbusy && n < 2000) begin @(negedge clk); n++; end
    check_eq(tag, 32'(a_txbusy), 0);
  endtask

  task automatic wait_idle_b(input string tag);
    int n = 0;
    while (b_txbusy && n < 2000) begin @(negedge clk); n++; end
    check_eq(tag, 32'(b_txbusy), 0);
  endtask

  task automatic pop_a(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, 32'(a_rxvalid), 1);
    check_eq(tag, 32'(a_q), 32'(exp));
    a_rd = 1'b1;
    @(negedge clk);
    a_rd = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [6:0] exp);
    check_eq({tag, "_valid"}, 32'(b_rxvalid), 1);
    check_eq(tag, 32'(b_q), 32'(exp));
    b_rd = 1'b1;
    @(negedge clk);
    b_rd = 1'b0;
  endtask

  task automatic drive(input bit sel_b, input logic v);
    if (sel_b) b_drv = v;
    else       a_drv = v;
  endtask

  // Bit-bang one frame in core polarity (space = 1) onto the selected rx line.
  task automatic send_frame(input bit sel_b, input logic [8:0] data, input int nbits,
                            input bit use_par, input logic parbit,
                            input logic stop_space, input int stop_clks);
    drive(sel_b, 1'b1);
    wait_clks(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      drive(sel_b, ~data[i]);
      wait_clks(BIT_CLKS);
    end
    if (use_par) begin
      drive(sel_b, ~parbit);
      wait_clks(BIT_CLKS);
    end
    drive(sel_b, stop_space);
    wait_clks(stop_clks);
    drive(sel_b, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_n = 1'b0; cte1 = 1'b1;
    a_load = 0; a_d = '0; a_rd = 0; a_clrerr = 0; a_loop = 1; a_drv = 0;
    b_load = 0; b_d = '0; b_rd = 0; b_clrerr = 0; b_loop = 1; b_drv = 0;
    wait_clks(3);

    // Reset state
    check_eq("rst_txpin",   32'(a_txpin), 0);
    check_eq("rst_txbusy",  32'(a_txbusy), 0);
    check_eq("rst_bitx8ce", 32'(a_bitx8ce), 0);
    check_eq("rst_rxvalid", 32'(a_rxvalid), 0);
    check_eq("rst_q",       32'(a_q), 0);
    check_eq("rst_flags",   32'({a_ovr, a_fe, a_pe, a_brk}), 0);
    rst_n = 1'b1;

    // Prescaler: one bitx8ce per CLKDIV=4 enabled clocks
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_bitx8ce) pulses++;
    end
    check_eq("presc_pulses", 32'(pulses), 10);

    // Loopback 0x41 then 0x4E; a load while busy must be ignored
    pulse_load_a(8'h41);
    wait_clks(60);
    check_eq("lb_busy", 32'(a_txbusy), 1);
    pulse_load_a(8'hFF);
    wait_idle_a("lb_idle1");
    check_eq("lb_valid1", 32'(a_rxvalid), 1);
    pulse_load_a(8'h4E);
    wait_idle_a("lb_idle2");
    wait_clks(8);
    pop_a("lb_q1", 8'h41);
    pop_a("lb_q2", 8'h4E);
    check_eq("lb_empty", 32'(a_rxvalid), 0);
    check_eq("lb_flags", 32'({a_ovr, a_fe, a_pe}), 0);

    // Overrun: 5 frames into a 4-deep FIFO
    for (int v = 1; v <= 5; v++) begin
      pulse_load_a(8'(v));
      wait_idle_a("ovr_idle");
    end
    wait_clks(8);
    check_eq("ovr_flag", 32'(a_ovr), 1);
    for (int v = 1; v <= 4; v++) pop_a("ovr_q", 8'(v));
    check_eq("ovr_empty", 32'(a_rxvalid), 0);
    a_rd = 1'b1; @(negedge clk); a_rd = 1'b0;
    check_eq("rd_empty_noop", 32'(a_rxvalid), 0);
    a_clrerr = 1'b1; @(negedge clk); a_clrerr = 1'b0;
    check_eq("ovr_clr", 32'(a_ovr), 0);

    // 3-tick space glitch is a false start
    a_loop = 0; a_drv = 0;
    wait_clks(8);
    a_drv = 1'b1; wait_clks(12); a_drv = 1'b0;
    wait_clks(64);
    check_eq("glitch_valid", 32'(a_rxvalid), 0);
    check_eq("glitch_flags", 32'({a_ovr, a_fe, a_pe}), 0);

    // Stop bit sampled as space: byte still pushed, framing error set
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 24);
    wait_clks(4);
    pop_a("fe_q", 8'h5A);
    check_eq("fe_flag", 32'(a_fe), 1);
    wait_clks(48);
    check_eq("fe_no_extra", 32'(a_rxvalid), 0);
    a_clrerr = 1'b1; @(negedge clk); a_clrerr = 1'b0;
    check_eq("fe_clr", 32'(a_fe), 0);

    // 7E1 loopback 0x55
    pulse_load_b(7'h55);
    wait_idle_b("par_idle");
    wait_clks(8);
    check_eq("par_ok_flags", 32'({b_pe, b_fe}), 0);
    pop_b("par_ok_q", 7'h55);

    // 7E1 with inverted parity bit (correct even parity of 0x55 is 0)
    b_loop = 0; b_drv = 0;
    wait_clks(8);
    send_frame(1'b1, 9'h055, 7, 1'b1, 1'b1, 1'b0, BIT_CLKS);
    wait_clks(4);
    check_eq("par_bad_flag", 32'(b_pe), 1);
    check_eq("par_bad_fe", 32'(b_fe), 0);
    pop_b("par_bad_q", 7'h55);
    b_clrerr = 1'b1; @(negedge clk); b_clrerr = 1'b0;
    check_eq("par_clr", 32'(b_pe), 0);

    // Asynchronous reset in the middle of a data bit
    a_loop = 1;
    wait_clks(8);
    pulse_load_a(8'h00);
    wait_clks(80);
    check_eq("arst_pre_txpin", 32'(a_txpin), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_txpin", 32'(a_txpin), 0);
    check_eq("arst_txbusy", 32'(a_txbusy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(40);
    check_eq("arst_empty", 32'(a_rxvalid), 0);
    pulse_load_a(8'hA5);
    wait_idle_a("arst_idle");
    wait_clks(8);
    pop_a("arst_q", 8'hA5);
    check_eq("arst_flags", 32'({a_ovr, a_fe, a_pe}), 0);

    // Line held at space for 12 bit times
    a_loop = 0; a_drv = 0;
    wait_clks(8);
    a_drv = 1'b1;
    wait_clks(12 * BIT_CLKS);
`ifdef UART_BREAK_DETECT_EN
    check_eq("brk_set", 32'(a_brk), 1);
    check_eq("brk_nopush", 32'(a_rxvalid), 0);
    check_eq("brk_fe", 32'(a_fe), 0);
    a_drv = 1'b0;
    wait_clks(16);
    check_eq("brk_hold", 32'(a_brk), 1);
    wait_clks(32);
    check_eq("brk_release", 32'(a_brk), 0);
`else
    check_eq("brk_tied", 32'(a_brk), 0);
    check_eq("brk_zero_q", 32'(a_q), 0);
    check_eq("brk_zero_valid", 32'(a_rxvalid), 1);
    check_eq("brk_zero_fe", 32'(a_fe), 1);
    a_drv = 1'b0;
    wait_clks(10 * BIT_CLKS);
    for (int k = 0; k < 8 && a_rxvalid; k++) begin
      a_rd = 1'b1; @(negedge clk); a_rd = 1'b0;
    end
    check_eq("brk_drained", 32'(a_rxvalid), 0);
    a_clrerr = 1'b1; @(negedge clk); a_clrerr = 1'b0;
`endif
    wait_clks(8);
    send_frame(1'b0, 9'h033, 8, 1'b0, 1'b0, 1'b0, BIT_CLKS);
    wait_clks(4);
    pop_a("post_brk_q", 8'h33);
    check_eq("post_brk_flags", 32'({a_ovr, a_fe, a_pe}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
